// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory arbiter: FSM state encoding, requester
// IDs used by the round-robin pointer, access length constants and the
// load-data byte mask helper.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BUSY_IF = 3'd1,
        S_BUSY_LD = 3'd2,
        S_BUSY_ST = 3'd3,
        S_DRAIN   = 3'd4
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_IF = 2'd0,
        REQ_LD = 2'd1,
        REQ_ST = 2'd2
    } req_id_t;

    localparam logic [3:0] LEN_BYTE  = 4'd1;
    localparam logic [3:0] LEN_HALF  = 4'd2;
    localparam logic [3:0] LEN_WORD  = 4'd4;
    localparam logic [3:0] LEN_DWORD = 4'd8;

    // Keep only the low 'len' bytes of a load; anything that is not a byte
    // or halfword access returns the full word.
    function automatic logic [31:0] mask_load(input logic [31:0] data,
                                              input logic [3:0]  len);
        logic [31:0] res;
        case (len)
            LEN_BYTE: res = {24'd0, data[7:0]};
            LEN_HALF: res = {16'd0, data[15:0]};
            default:  res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three requester ports (fetch, load, store) and the single
// downstream memory-controller command port.
//
// Handshake: a requester raises x_req with stable fields and holds it until
// it sees x_done (a one-cycle pulse). The arbiter raises mc_req with stable
// mc_* fields and holds them until it samples mc_done=1; mc_done is only
// meaningful while mc_req is high.
//
// Modports: slave = arbiter side, master = requesters + memory controller.
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_a;
    logic [63:0] if_data;
    logic        if_done;

    logic        ld_req;
    logic [2:0]  ld_len;
    logic [31:0] ld_a;
    logic [31:0] ld_data;
    logic        ld_done;

    logic        st_req;
    logic [2:0]  st_len;
    logic [31:0] st_a;
    logic [31:0] st_din;
    logic        st_done;

    logic        mc_req;
    logic        mc_wr;
    logic [3:0]  mc_len;
    logic [31:0] mc_a;
    logic [31:0] mc_din;
    logic [63:0] mc_dout;
    logic        mc_done;

    modport slave (
        input  if_req, if_a, ld_req, ld_len, ld_a,
               st_req, st_len, st_a, st_din, mc_dout, mc_done,
        output if_data, if_done, ld_data, ld_done, st_done,
               mc_req, mc_wr, mc_len, mc_a, mc_din
    );

    modport master (
        output if_req, if_a, ld_req, ld_len, ld_a,
               st_req, st_len, st_a, st_din, mc_dout, mc_done,
        input  if_data, if_done, ld_data, ld_done, st_done,
               mc_req, mc_wr, mc_len, mc_a, mc_din
    );
endinterface

// File: rtl/mem_arbiter_rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Combinational 3-way round-robin picker. Search order starts at the
// requester after i_last (IF -> LD -> ST -> IF).
// Ports: i_elig  eligible mask (bit0 IF, bit1 LD, bit2 ST)
//        i_last  last granted requester
//        o_grant one-hot grant, all zero if nobody is eligible
// -----------------------------------------------------------------------------
module rr_pick3
    import mem_arb_pkg::*;
(
    input  logic [2:0] i_elig,
    input  req_id_t    i_last,
    output logic [2:0] o_grant
);

    always_comb begin
        o_grant = 3'b000;
        case (i_last)
            REQ_IF: begin
                if      (i_elig[1]) o_grant = 3'b010;
                else if (i_elig[2]) o_grant = 3'b100;
                else if (i_elig[0]) o_grant = 3'b001;
            end
            REQ_LD: begin
                if      (i_elig[2]) o_grant = 3'b100;
                else if (i_elig[0]) o_grant = 3'b001;
                else if (i_elig[1]) o_grant = 3'b010;
            end
            default: begin
                if      (i_elig[0]) o_grant = 3'b001;
                else if (i_elig[1]) o_grant = 3'b010;
                else if (i_elig[2]) o_grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates instruction fetch, load and store requesters onto one
// downstream memory-controller command port, one command at a time.
// Ports: clk_in, rst_n_in (async, active low), rdy_in (global stall),
//        flush_in (cancels fetch/load), bus (mem_arbiter_if.slave),
//        o_dbg_state / o_dbg_last_grant (FSM state and RR pointer).
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [3:0] IF_LEN = LEN_DWORD
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    input  logic               flush_in,
    mem_arbiter_if.slave       bus,
    output arb_state_t         o_dbg_state,
    output req_id_t            o_dbg_last_grant
);

    arb_state_t  r_state,   w_state_n;
    req_id_t     r_last,    w_last_n;
    logic        r_mc_req,  w_mc_req_n;
    logic        r_mc_wr,   w_mc_wr_n;
    logic [3:0]  r_mc_len,  w_mc_len_n;
    logic [31:0] r_mc_a,    w_mc_a_n;
    logic [31:0] r_mc_din,  w_mc_din_n;
    logic        r_if_done, w_if_done_n;
    logic        r_ld_done, w_ld_done_n;
    logic        r_st_done, w_st_done_n;
    logic [63:0] r_if_data, w_if_data_n;
    logic [31:0] r_ld_data, w_ld_data_n;

    logic [2:0]  w_elig;
    logic [2:0]  w_grant;
    logic        w_mc_fin;

    // A requester whose done pulse is currently showing is still holding
    // req high; masking it here stops it being granted a second time.
    assign w_elig = {bus.st_req & ~r_st_done,
                     bus.ld_req & ~r_ld_done & ~flush_in,
                     bus.if_req & ~r_if_done & ~flush_in};

    // mc_done only counts while a command is outstanding.
    assign w_mc_fin = r_mc_req & bus.mc_done;

    rr_pick3 u_pick (
        .i_elig  (w_elig),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    always_comb begin
        w_state_n   = r_state;
        w_last_n    = r_last;
        w_mc_req_n  = r_mc_req;
        w_mc_wr_n   = r_mc_wr;
        w_mc_len_n  = r_mc_len;
        w_mc_a_n    = r_mc_a;
        w_mc_din_n  = r_mc_din;
        w_if_done_n = 1'b0;
        w_ld_done_n = 1'b0;
        w_st_done_n = 1'b0;
        w_if_data_n = r_if_data;
        w_ld_data_n = r_ld_data;

        case (r_state)
            S_IDLE: begin
                if (w_grant[0]) begin
                    w_state_n  = S_BUSY_IF;
                    w_last_n   = REQ_IF;
                    w_mc_req_n = 1'b1;
                    w_mc_wr_n  = 1'b0;
                    w_mc_len_n = IF_LEN;
                    w_mc_a_n   = bus.if_a;
                    w_mc_din_n = '0;
                end else if (w_grant[1]) begin
                    w_state_n  = S_BUSY_LD;
                    w_last_n   = REQ_LD;
                    w_mc_req_n = 1'b1;
                    w_mc_wr_n  = 1'b0;
                    w_mc_len_n = {1'b0, bus.ld_len};
                    w_mc_a_n   = bus.ld_a;
                    w_mc_din_n = '0;
                end else if (w_grant[2]) begin
                    w_state_n  = S_BUSY_ST;
                    w_last_n   = REQ_ST;
                    w_mc_req_n = 1'b1;
                    w_mc_wr_n  = 1'b1;
                    w_mc_len_n = {1'b0, bus.st_len};
                    w_mc_a_n   = bus.st_a;
                    w_mc_din_n = bus.st_din;
                end
            end
            S_BUSY_IF: begin
                // A flush coinciding with mc_done still cancels the result.
                if (flush_in) begin
                    w_state_n = w_mc_fin ? S_IDLE : S_DRAIN;
                    if (w_mc_fin) w_mc_req_n = 1'b0;
                end else if (w_mc_fin) begin
                    w_state_n   = S_IDLE;
                    w_mc_req_n  = 1'b0;
                    w_if_done_n = 1'b1;
                    w_if_data_n = bus.mc_dout;
                end
            end
            S_BUSY_LD: begin
                if (flush_in) begin
                    w_state_n = w_mc_fin ? S_IDLE : S_DRAIN;
                    if (w_mc_fin) w_mc_req_n = 1'b0;
                end else if (w_mc_fin) begin
                    w_state_n   = S_IDLE;
                    w_mc_req_n  = 1'b0;
                    w_ld_done_n = 1'b1;
                    w_ld_data_n = mask_load(bus.mc_dout[31:0], r_mc_len);
                end
            end
            S_BUSY_ST: begin
                if (w_mc_fin) begin
                    w_state_n   = S_IDLE;
                    w_mc_req_n  = 1'b0;
                    w_st_done_n = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_mc_fin) begin
                    w_state_n  = S_IDLE;
                    w_mc_req_n = 1'b0;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // rdy_in low freezes every register, including the done pulses.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= S_IDLE;
            r_last    <= REQ_ST;
            r_mc_req  <= 1'b0;
            r_mc_wr   <= 1'b0;
            r_mc_len  <= '0;
            r_mc_a    <= '0;
            r_mc_din  <= '0;
            r_if_done <= 1'b0;
            r_ld_done <= 1'b0;
            r_st_done <= 1'b0;
            r_if_data <= '0;
            r_ld_data <= '0;
        end else if (rdy_in) begin
            r_state   <= w_state_n;
            r_last    <= w_last_n;
            r_mc_req  <= w_mc_req_n;
            r_mc_wr   <= w_mc_wr_n;
            r_mc_len  <= w_mc_len_n;
            r_mc_a    <= w_mc_a_n;
            r_mc_din  <= w_mc_din_n;
            r_if_done <= w_if_done_n;
            r_ld_done <= w_ld_done_n;
            r_st_done <= w_st_done_n;
            r_if_data <= w_if_data_n;
            r_ld_data <= w_ld_data_n;
        end
    end

    assign bus.mc_req  = r_mc_req;
    assign bus.mc_wr   = r_mc_wr;
    assign bus.mc_len  = r_mc_len;
    assign bus.mc_a    = r_mc_a;
    assign bus.mc_din  = r_mc_din;
    assign bus.if_done = r_if_done;
    assign bus.ld_done = r_ld_done;
    assign bus.st_done = r_st_done;
    assign bus.if_data = r_if_data;
    assign bus.ld_data = r_ld_data;

    assign o_dbg_state      = r_state;
    assign o_dbg_last_grant = r_last;

endmodule
